load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits directly downstream of the ALU: takes the ALU result as the effective address for loads and stores, and rs2 as store data.
- Runs a handshaked request/response transaction on the data-memory bus and generates byte enables.
- Returns sign- or zero-extended load data to writeback.
- Asserts stall to freeze the PC and register writes until the access completes.

Parameters:
- TIMEOUT_CYCLES, 256, watchdog limit in cycles spent in REQ+WAIT (used only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  current instruction is a load or store
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32I funct3 (size/signedness)
- req_addr  in  32  effective address (ALU result)
- req_wdata  in  32  store data (rs2)
- stall  out  1  hold processor this cycle
- load_data  out  32  extended load result
- load_valid  out  1  load_data valid (DONE cycle of a load)
- fault  out  1  misaligned/illegal access or timeout
- bus_req  out  1  bus request
- bus_we  out  1  bus write
- bus_addr  out  32  word-aligned address ({req_addr[31:2],2'b00})
- bus_wdata  out  32  lane-replicated write data
- bus_be  out  4  byte enables
- bus_gnt  in  1  request accepted
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read data

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (async, immediate): state=IDLE; bus_req, bus_we, bus_be, bus_addr, bus_wdata, load_data, load_valid, fault = 0; stall forced 0 while rst_n=0.
- Reset mid-transaction: the bus request is dropped immediately. Any bus_rvalid after reset release is ignored in IDLE.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - req_valid=1 and access legal: register bus_* outputs, bus_req=1, go to REQ; stall=1 combinationally in this cycle.
  - req_valid=1 and access illegal: fault=1 combinationally, stall=0, no bus activity, stay IDLE.
- Legality rules:
  - LH/LHU/SH with addr[0]=1: illegal.
  - LW/SW with addr[1:0]!=0: illegal.
  - Load funct3 011/110/111: illegal.
  - Store funct3 other than 000/001/010: illegal.
- REQ:
  - bus_req/we/addr/be/wdata held stable until bus_gnt=1 is sampled.
  - Store + gnt: drop bus_req, go to DONE.
  - Load + gnt: drop bus_req, go to WAIT. If bus_rvalid=1 in the same cycle, capture data and go directly to DONE.
- WAIT: on bus_rvalid=1, capture formatted data into load_data and go to DONE.
- DONE: one cycle; stall=0, load_valid=1 for loads, then go to IDLE unconditionally. req_valid is ignored in DONE (the processor advances at this edge).
- stall = (IDLE & req_valid & legal) | REQ | WAIT.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: be=addr[1]?1100:0011, wdata={2{rs2[15:0]}}.
  - SW: be=1111.
- Loads: bus_be=1111 for all loads. The byte/half is selected by addr[1:0]/addr[1] from bus_rdata. LB/LH sign-extend; LBU/LHU zero-extend.
- Latency, zero-wait bus: store 2 stall cycles then DONE; load 3 stall cycles if rvalid arrives 1 cycle after gnt.
- load_data holds its last value until the next load capture. fault is combinational in IDLE only (timeout case below).

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - A counter clears on entering REQ and increments each cycle in REQ/WAIT.
  - When it reaches TIMEOUT_CYCLES-1: bus_req drops, go to DONE with load_data=0 and fault=1 registered for the DONE cycle.
- Undefined: no counter; the unit waits indefinitely.

Test Plan:
- SW addr 0x0000_1004, data 0xDEADBEEF, gnt in first REQ cycle -> bus_addr 0x1004, be 1111, wdata 0xDEADBEEF; stall high 2 cycles; DONE with fault 0.
- SB addr 0x1003, rs2 0x000000A5 -> be 1000, wdata 0xA5A5A5A5. SH addr 0x1002 -> be 1100.
- LB addr 0x1001, rdata 0x0000_8000 after 3-cycle gnt delay + 2-cycle rvalid delay -> load_data 0xFFFFFF80, load_valid 1 cycle. LBU same case -> 0x00000080. LHU addr 0x1002, rdata 0xBEEF0000 -> 0x0000BEEF.
- LW addr 0x1002 -> fault 1, stall 0, bus_req never asserts. Load funct3 011 -> same response.
- Load with gnt and rvalid in the same cycle, rdata 0x12345678 -> direct REQ->DONE, load_data 0x12345678.
- rst_n low during WAIT -> bus_req 0 and state IDLE immediately; a late rvalid after release produces no load_valid. With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=8, gnt held low -> DONE after 8 cycles with fault 1 and load_data 0.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns ALU-computed load/store requests into a handshaked
// data-memory bus transaction, formats load data, and stalls the pipeline
// until the access completes.
// Optional feature macro: LSU_TIMEOUT_EN (watchdog of TIMEOUT_CYCLES cycles
// spent in REQ+WAIT; on expiry the access ends with fault and load_data=0).
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    state_t      state_q, state_d;
    logic        bus_req_d, bus_we_d;
    logic [31:0] bus_addr_d, bus_wdata_d, load_data_d;
    logic [3:0]  bus_be_d;
    logic        load_valid_d;
    logic        fault_q, fault_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  offset_q, offset_d;
    logic        legal;

    // Access legality: supported funct3 and natural alignment for its size.
    function automatic logic access_legal(input logic we, input logic [2:0] f3,
                                          input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        if (we) begin
            case (f3)
                F3_B:    ok = 1'b1;
                F3_H:    ok = ~off[0];
                F3_W:    ok = (off == 2'b00);
                default: ok = 1'b0;
            endcase
        end else begin
            case (f3)
                F3_B, F3_BU: ok = 1'b1;
                F3_H, F3_HU: ok = ~off[0];
                F3_W:        ok = (off == 2'b00);
                default:     ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Select the addressed byte/half from the bus word and extend it.
    function automatic logic [31:0] format_load(input logic [31:0] rdata,
                                                input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_BU:   r = {24'b0, b};
            F3_HU:   r = {16'b0, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    assign legal = access_legal(req_we, req_funct3, req_addr[1:0]);

    // Next-state, registered-output next values and combinational stall/fault.
    always_comb begin
        state_d      = state_q;
        bus_req_d    = bus_req;
        bus_we_d     = bus_we;
        bus_addr_d   = bus_addr;
        bus_wdata_d  = bus_wdata;
        bus_be_d     = bus_be;
        load_data_d  = load_data;
        load_valid_d = 1'b0;
        fault_d      = 1'b0;
        funct3_d     = funct3_q;
        offset_d     = offset_q;
        stall        = 1'b0;
        fault        = fault_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d        = (state_q == ST_REQ || state_q == ST_WAIT) ? cnt_q + CNT_W'(1) : '0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (legal) begin
                        stall      = 1'b1;
                        state_d    = ST_REQ;
                        bus_req_d  = 1'b1;
                        bus_we_d   = req_we;
                        bus_addr_d = {req_addr[31:2], 2'b00};
                        funct3_d   = req_funct3;
                        offset_d   = req_addr[1:0];
                        if (req_we) begin
                            case (req_funct3[1:0])
                                2'b00: begin
                                    bus_be_d    = 4'b0001 << req_addr[1:0];
                                    bus_wdata_d = {4{req_wdata[7:0]}};
                                end
                                2'b01: begin
                                    bus_be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
                                    bus_wdata_d = {2{req_wdata[15:0]}};
                                end
                                default: begin
                                    bus_be_d    = 4'b1111;
                                    bus_wdata_d = req_wdata;
                                end
                            endcase
                        end else begin
                            bus_be_d    = 4'b1111;
                            bus_wdata_d = 32'h0;
                        end
                    end else begin
                        fault = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                if (bus_gnt) begin
                    bus_req_d = 1'b0;
                    if (bus_we) begin
                        state_d = ST_DONE;
                    end else if (bus_rvalid) begin
                        load_data_d  = format_load(bus_rdata, funct3_q, offset_q);
                        load_valid_d = 1'b1;
                        state_d      = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (bus_rvalid) begin
                    load_data_d  = format_load(bus_rdata, funct3_q, offset_q);
                    load_valid_d = 1'b1;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef LSU_TIMEOUT_EN
        // Watchdog expiry abandons the access unless it completes this cycle.
        if ((state_q == ST_REQ || state_q == ST_WAIT) && state_d != ST_DONE &&
            cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d      = ST_DONE;
            bus_req_d    = 1'b0;
            load_data_d  = 32'h0;
            load_valid_d = ~bus_we;
            fault_d      = 1'b1;
        end
`endif

        // The processor must not be held or faulted while in reset.
        if (!rst_n) begin
            stall = 1'b0;
            fault = 1'b0;
        end
    end

    // State and registered outputs; reset drops any bus request immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'h0;
            bus_wdata  <= 32'h0;
            bus_be     <= 4'h0;
            load_data  <= 32'h0;
            load_valid <= 1'b0;
            fault_q    <= 1'b0;
            funct3_q   <= 3'b0;
            offset_q   <= 2'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            bus_req    <= bus_req_d;
            bus_we     <= bus_we_d;
            bus_addr   <= bus_addr_d;
            bus_wdata  <= bus_wdata_d;
            bus_be     <= bus_be_d;
            load_data  <= load_data_d;
            load_valid <= load_valid_d;
            fault_q    <= fault_d;
            funct3_q   <= funct3_d;
            offset_q   <= offset_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver issues requests and plays
// the bus, pushing expected responses; a monitor pops and compares them.
module tb_load_store_unit;

    localparam int unsigned TO = 8;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .load_data(load_data), .load_valid(load_valid), .fault(fault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          illegal;
        bit          is_load;
        logic [31:0] data;
        bit          flt;
        int          stall_cyc;
    } resp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    resp_t       resp_q[$];
    bus_t        bus_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] last_load = 32'h0;

    function void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model (size/alignment arithmetic) ----------------
    function automatic int unsigned acc_size(input logic [2:0] f3);
        return 32'd1 << f3[1:0];
    endfunction

    function automatic bit model_legal(input bit we, input logic [2:0] f3, input logic [31:0] addr);
        bit ok_f3;
        ok_f3 = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return ok_f3 && ((addr % acc_size(f3)) == 0);
    endfunction

    function automatic logic [3:0] model_be(input bit we, input logic [2:0] f3, input logic [31:0] addr);
        logic [3:0]  be;
        int unsigned off;
        if (!we) return 4'hF;
        be  = 4'h0;
        off = addr % 4;
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + acc_size(f3)) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        logic [31:0] w;
        int unsigned sz;
        sz = acc_size(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        longint      v;
        int unsigned sz;
        int unsigned off;
        sz  = acc_size(f3);
        off = addr % 4;
        v   = (longint'(rdata) >> (8 * off)) & ((64'sd1 <<< (8 * sz)) - 1);
        if (f3[2] == 1'b0 && sz < 4 && ((v >>> (8 * sz - 1)) & 1) == 1)
            v = v - (64'sd1 <<< (8 * sz));
        return 32'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One processor request plus the bus slave's handshake for it.
    task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int gnt_dly, input int rv_dly, input bit same);
        resp_t r;
        bus_t  b;
        bit    legal;
        bit    ld;
        legal       = model_legal(we, f3, addr);
        ld          = !we;
        r.illegal   = !legal;
        r.is_load   = ld;
        r.flt       = !legal;
        r.data      = (legal && ld) ? model_load(f3, addr, rd) : last_load;
        r.stall_cyc = legal ? (2 + gnt_dly + ((ld && !same) ? 1 + rv_dly : 0)) : 0;
        last_load   = r.data;
        resp_q.push_back(r);
        if (legal) begin
            b.we    = we;
            b.addr  = {addr[31:2], 2'b00};
            b.be    = model_be(we, f3, addr);
            b.wdata = we ? model_wdata(f3, wd) : 32'h0;
            bus_q.push_back(b);
        end
        tick();
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        if (!legal) begin
            tick();
            req_valid = 1'b0;
            return;
        end
        tick();
        repeat (gnt_dly) tick();
        bus_gnt = 1'b1;
        if (ld && same) begin
            bus_rvalid = 1'b1;
            bus_rdata  = rd;
        end
        tick();
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = $urandom;
        if (ld && !same) begin
            repeat (rv_dly) tick();
            bus_rvalid = 1'b1;
            bus_rdata  = rd;
            tick();
            bus_rvalid = 1'b0;
            bus_rdata  = $urandom;
        end
        req_valid = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        int    stall_cnt;
        bit    prev_stall;
        bit    prev_breq;
        resp_t r;
        bus_t  b;
        stall_cnt  = 0;
        prev_stall = 1'b0;
        prev_breq  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_cnt  = 0;
                prev_stall = 1'b0;
                prev_breq  = 1'b0;
            end else begin
                if (bus_req && !prev_breq) begin
                    if (bus_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL bus_unexpected: bus_req rose with no request pending at %0t", $time);
                    end else begin
                        b = bus_q.pop_front();
                        check("bus_we", 32'(bus_we), 32'(b.we));
                        check("bus_addr", bus_addr, b.addr);
                        check("bus_be", 32'(bus_be), 32'(b.be));
                        if (b.we) check("bus_wdata", bus_wdata, b.wdata);
                    end
                end
                if (stall) begin
                    stall_cnt++;
                end else if (prev_stall || fault || load_valid) begin
                    if (resp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL resp_unexpected: fault=%0b load_valid=%0b with nothing pending at %0t",
                                 fault, load_valid, $time);
                    end else begin
                        r = resp_q.pop_front();
                        check("fault", 32'(fault), 32'(r.flt));
                        check("load_valid", 32'(load_valid), 32'(!r.illegal && r.is_load));
                        check("load_data", load_data, r.data);
                        check("stall_cycles", 32'(stall_cnt), 32'(r.stall_cyc));
                        if (r.illegal) check("illegal_no_bus", 32'(bus_req), 32'd0);
                    end
                    stall_cnt = 0;
                end
                prev_stall = stall;
                prev_breq  = bus_req;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "simulation time limit");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [31:0] a;
        logic [2:0]  f3;
        bit          we;
        bit          done;
        resp_t       r;
        bus_t        b;

        rst_n      = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h40;
        req_wdata  = 32'h0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h0;

        // Outputs during reset, with a legal request presented.
        #22;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_bus_be", 32'(bus_be), 32'd0);
        check("rst_load_data", load_data, 32'h0);
        check("rst_load_valid", 32'(load_valid), 32'd0);
        req_valid = 1'b0;
        tick();
        rst_n = 1'b1;

        // Directed cases.
        issue(1'b1, 3'b010, 32'h0000_1004, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0);
        issue(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 0, 1'b0);
        issue(1'b1, 3'b001, 32'h0000_1002, 32'h1234_BEEF, 32'h0, 1, 0, 1'b0);
        issue(1'b0, 3'b000, 32'h0000_1001, 32'h0, 32'h0000_8000, 3, 2, 1'b0);
        issue(1'b0, 3'b100, 32'h0000_1001, 32'h0, 32'h0000_8000, 3, 2, 1'b0);
        issue(1'b0, 3'b101, 32'h0000_1002, 32'h0, 32'hBEEF_0000, 0, 0, 1'b0);
        issue(1'b0, 3'b010, 32'h0000_1002, 32'h0, 32'h0, 0, 0, 1'b0);
        issue(1'b0, 3'b011, 32'h0000_1000, 32'h0, 32'h0, 0, 0, 1'b0);
        issue(1'b1, 3'b011, 32'h0000_1000, 32'h0, 32'h0, 0, 0, 1'b0);
        issue(1'b0, 3'b010, 32'h0000_1000, 32'h0, 32'h1234_5678, 1, 0, 1'b1);
        issue(1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 0, 0, 1'b0);

`ifdef LSU_TIMEOUT_EN
        // Grant never arrives: watchdog abandons the load.
        r.illegal   = 1'b0;
        r.is_load   = 1'b1;
        r.data      = 32'h0;
        r.flt       = 1'b1;
        r.stall_cyc = 1 + TO;
        last_load   = 32'h0;
        resp_q.push_back(r);
        b.we = 1'b0; b.addr = 32'h0000_3000; b.be = 4'hF; b.wdata = 32'h0;
        bus_q.push_back(b);
        tick();
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_3000;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (!stall) done = 1'b1;
        end
        check("timeout_reached_done", 32'(done), 32'd1);
        req_valid = 1'b0;
`else
        // Without the watchdog a slow grant is simply waited for.
        done = 1'b1;
        issue(1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'hA5A5_5A5A, 20, 0, 1'b0);
`endif

        // Reset while waiting for read data; a late rvalid must be ignored.
        b.we = 1'b0; b.addr = 32'h0000_2000; b.be = 4'hF; b.wdata = 32'h0;
        bus_q.push_back(b);
        tick();
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_2000;
        tick();
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        check("wait_stall", 32'(stall), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_bus_req", 32'(bus_req), 32'd0);
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_load_valid", 32'(load_valid), 32'd0);
        req_valid = 1'b0;
        tick();
        rst_n      = 1'b1;
        last_load  = 32'h0;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hCAFE_F00D;
        tick();
        bus_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("late_rvalid_load_valid", 32'(load_valid), 32'd0);
            check("late_rvalid_stall", 32'(stall), 32'd0);
            check("late_rvalid_load_data", load_data, 32'h0);
            tick();
        end

        // Randomized mix, mostly aligned, delays kept under the watchdog limit.
        for (int n = 0; n < 80; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(acc_size(f3) - 1);
            issue(we, f3, a, $urandom, $urandom, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0));
        end

        repeat (4) tick();
        check("resp_q_drained", 32'(resp_q.size()), 32'd0);
        check("bus_q_drained", 32'(bus_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
